// File: rtl/flags_stage_if.sv
// Bundles the D->E flag-stage inputs and outputs.
// The master side is the decode, hazard and checker logic; the slave side is flags_stage.
interface flags_stage_if #(
  parameter int unsigned CNT_W = 16
);
  logic [3:0]       CondD;
  logic [1:0]       FlagsWriteD;
  logic             ValidD;
  logic             StallE;
  logic             FlushE;
  logic [3:0]       FlagsNext;
  logic             CondExE;
  logic             SaveFlags;
  logic             RestoreFlags;
  logic [3:0]       CondE;
  logic [1:0]       FlagsWriteE;
  logic             ValidE;
  logic [3:0]       Flags;
  logic             CondUndefE;
  logic [CNT_W-1:0] ExecCnt;
  logic [CNT_W-1:0] SkipCnt;
  logic [3:0]       FlagsShadow;

  modport master (
    output CondD, FlagsWriteD, ValidD, StallE, FlushE, FlagsNext, CondExE,
           SaveFlags, RestoreFlags,
    input  CondE, FlagsWriteE, ValidE, Flags, CondUndefE, ExecCnt, SkipCnt, FlagsShadow
  );

  modport slave (
    input  CondD, FlagsWriteD, ValidD, StallE, FlushE, FlagsNext, CondExE,
           SaveFlags, RestoreFlags,
    output CondE, FlagsWriteE, ValidE, Flags, CondUndefE, ExecCnt, SkipCnt, FlagsShadow
  );
endinterface

// File: rtl/flags_stage.sv
// Execute-stage condition/flag holder: D->E register, NZCV state and retire counters.
// Optional NZCV shadow register is enabled with `define FLAGS_SHADOW_EN.
module flags_stage #(
  parameter int unsigned CNT_W       = 16,
  parameter logic [3:0]  RESET_FLAGS = 4'b0000
) (
  input logic         clk,
  input logic         reset,
  flags_stage_if.slave bus
);
  localparam logic [3:0] CondAl = 4'b1110;

  logic [3:0]       cond_q, cond_d;
  logic [1:0]       fwe_q, fwe_d;
  logic             valid_q, valid_d;
  logic [3:0]       flags_q, flags_d;
  logic [CNT_W-1:0] exec_q, exec_d;
  logic [CNT_W-1:0] skip_q, skip_d;
  logic             retire;
  logic             undef;
  logic [3:0]       flags_upd;

  assign retire = valid_q & ~bus.StallE;
  assign undef  = valid_q & (cond_q == 4'b1111);

  always_comb begin
    cond_d  = cond_q;
    fwe_d   = fwe_q;
    valid_d = valid_q;
    if (bus.FlushE) begin
      cond_d  = CondAl;
      fwe_d   = 2'b00;
      valid_d = 1'b0;
    end else if (!bus.StallE) begin
      cond_d  = bus.CondD;
      fwe_d   = bus.FlagsWriteD & {2{bus.ValidD}};
      valid_d = bus.ValidD;
    end
  end

  // Undefined-condition instructions retire without touching NZCV.
  assign flags_upd = (retire && !undef) ? bus.FlagsNext : flags_q;

  always_comb begin
    exec_d = exec_q;
    skip_d = skip_q;
    if (retire) begin
      if (bus.CondExE && !undef) begin
        if (exec_q != '1) exec_d = exec_q + 1'b1;
      end else begin
        if (skip_q != '1) skip_d = skip_q + 1'b1;
      end
    end
  end

`ifdef FLAGS_SHADOW_EN
  logic [3:0] shadow_q, shadow_d;

  always_comb begin
    flags_d  = flags_upd;
    shadow_d = shadow_q;
    if (bus.RestoreFlags) begin
      flags_d = shadow_q;
    end else if (bus.SaveFlags) begin
      shadow_d = flags_upd;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) shadow_q <= 4'b0000;
    else       shadow_q <= shadow_d;
  end

  assign bus.FlagsShadow = shadow_q;
`else
  always_comb begin
    flags_d = flags_upd;
  end

  assign bus.FlagsShadow = 4'b0000;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cond_q  <= CondAl;
      fwe_q   <= 2'b00;
      valid_q <= 1'b0;
      flags_q <= RESET_FLAGS;
      exec_q  <= '0;
      skip_q  <= '0;
    end else begin
      cond_q  <= cond_d;
      fwe_q   <= fwe_d;
      valid_q <= valid_d;
      flags_q <= flags_d;
      exec_q  <= exec_d;
      skip_q  <= skip_d;
    end
  end

  assign bus.CondE       = cond_q;
  assign bus.FlagsWriteE = fwe_q;
  assign bus.ValidE      = valid_q;
  assign bus.Flags       = flags_q;
  assign bus.CondUndefE  = undef;
  assign bus.ExecCnt     = exec_q;
  assign bus.SkipCnt     = skip_q;
endmodule
